// File: rtl/blink_meter_pkg.sv
// Shared blink-block definitions: measurement FSM states
// and default counter width / stuck timeout.
package blink_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 30;
  localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/blink_meter_sync_edge.sv
// 2-flop synchronizer plus edge register for an async input.
// Ports: clk, rst, sig_in -> level, rise, fall (all registered-based).
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/blink_meter.sv
// Blink meter: measures period and high time of sig_in, flags stuck input.
// Ports: clk, rst, sig_in -> period_cnt, high_cnt, valid, stuck, stuck_level.
module blink_meter
  import blink_meter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_cnt,
  output logic [WIDTH-1:0] high_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_TO  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic level;
  logic rise;
  logic fall;

  sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_tmp_q, high_tmp_d;
  logic [WIDTH-1:0] cap_period_q, cap_period_d;
  logic [WIDTH-1:0] cap_high_q, cap_high_d;
  logic             pend_q, pend_d;
  logic             stuck_q, stuck_d;
  logic             slvl_q, slvl_d;

  logic [WIDTH-1:0] cnt_inc;
  logic             timeout;

  // Saturating increment; after an edge-wins at a full-scale
  // timeout the counter must stay >= TIMEOUT, not wrap to 0.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign timeout = (cnt_q >= CNT_TO);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_tmp_d   = high_tmp_q;
    cap_period_d = cap_period_q;
    cap_high_d   = cap_high_q;
    pend_d       = 1'b0;
    stuck_d      = stuck_q;
    slvl_d       = slvl_q;
    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEAS_HIGH;
          cnt_d   = CNT_ONE;
          stuck_d = 1'b0;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          high_tmp_d = cnt_q;
          cnt_d      = cnt_inc;
          state_d    = MEAS_LOW;
        end else if (timeout) begin
          stuck_d = 1'b1;
          slvl_d  = level;
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          cap_period_d = cnt_q;
          cap_high_d   = high_tmp_q;
          pend_d       = 1'b1;
          cnt_d        = CNT_ONE;
          state_d      = MEAS_HIGH;
        end else if (timeout) begin
          stuck_d = 1'b1;
          slvl_d  = level;
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = WAIT_RISE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_RISE;
      cnt_q        <= '0;
      high_tmp_q   <= '0;
      cap_period_q <= '0;
      cap_high_q   <= '0;
      pend_q       <= 1'b0;
      stuck_q      <= 1'b0;
      slvl_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_tmp_q   <= high_tmp_d;
      cap_period_q <= cap_period_d;
      cap_high_q   <= cap_high_d;
      pend_q       <= pend_d;
      stuck_q      <= stuck_d;
      slvl_q       <= slvl_d;
    end
  end

  // Output stage: results move out together with valid,
  // one cycle after the closing rise is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= pend_q;
      if (pend_q) begin
        period_cnt <= cap_period_q;
        high_cnt   <= cap_high_q;
      end
    end
  end

  assign stuck       = stuck_q;
  assign stuck_level = slvl_q;

endmodule

// File: tb/tb_blink_meter.sv
// Self-checking bench for blink_meter: index-based reference model
// compared every cycle, plus directed literal checks.
module tb_blink_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  logic sig4 = 1'b0;

  logic [29:0] period_cnt, high_cnt;
  logic        valid, stuck, stuck_level;
  logic [3:0]  period4, high4;
  logic        valid4, stuck4, slvl4;

  always #5 clk = ~clk;

  blink_meter dut (
    .clk(clk), .rst(rst), .sig_in(sig),
    .period_cnt(period_cnt), .high_cnt(high_cnt),
    .valid(valid), .stuck(stuck), .stuck_level(stuck_level)
  );

  blink_meter #(.WIDTH(4), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig4),
    .period_cnt(period4), .high_cnt(high4),
    .valid(valid4), .stuck(stuck4), .stuck_level(slvl4)
  );

  // Model: edges are located by sample index; period and high time
  // are index differences between the rises/fall that bound them.
  typedef struct {
    int t; int r; int f; int ph;
    bit h0; bit h1; bit h2;
    bit pend; int pp; int phh;
    int period; int high;
    bit valid; bit stuck; bit lvl;
  } mdl_t;

  function automatic mdl_t step(mdl_t m, bit r, bit s, int to);
    bit cur, prv, rs, fl;
    if (r) begin
      m = '{default:0};
      return m;
    end
    cur = m.h1;
    prv = m.h2;
    m.h2 = m.h1;
    m.h1 = m.h0;
    m.h0 = s;
    m.valid = m.pend;
    if (m.pend) begin
      m.period = m.pp;
      m.high = m.phh;
    end
    m.pend = 0;
    rs = cur & !prv;
    fl = !cur & prv;
    case (m.ph)
      0: if (rs) begin
        m.ph = 1; m.r = m.t; m.stuck = 0;
      end
      1: if (fl) begin
        m.f = m.t; m.ph = 2;
      end else if (m.t - m.r >= to) begin
        m.stuck = 1; m.lvl = cur; m.ph = 0;
      end
      default: if (rs) begin
        m.pend = 1; m.pp = m.t - m.r; m.phh = m.f - m.r;
        m.r = m.t; m.ph = 1;
      end else if (m.t - m.r >= to) begin
        m.stuck = 1; m.lvl = cur; m.ph = 0;
      end
    endcase
    m.t++;
    return m;
  endfunction

  mdl_t m0 = '{default:0};
  mdl_t m1 = '{default:0};

  always @(posedge clk) begin
    m0 <= step(m0, rst, sig, 1000);
    m1 <= step(m1, rst, sig4, 15);
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (period_cnt !== 30'(m0.period) || high_cnt !== 30'(m0.high) ||
          valid !== m0.valid || stuck !== m0.stuck ||
          stuck_level !== m0.lvl) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL cycle_w30 t=%0t: got p=%0d h=%0d v=%b s=%b l=%b expected p=%0d h=%0d v=%b s=%b l=%b",
                   $time, period_cnt, high_cnt, valid, stuck, stuck_level,
                   m0.period, m0.high, m0.valid, m0.stuck, m0.lvl);
      end
      n_chk++;
      if (period4 !== 4'(m1.period) || high4 !== 4'(m1.high) ||
          valid4 !== m1.valid || stuck4 !== m1.stuck ||
          slvl4 !== m1.lvl) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL cycle_w4 t=%0t: got p=%0d h=%0d v=%b s=%b l=%b expected p=%0d h=%0d v=%b s=%b l=%b",
                   $time, period4, high4, valid4, stuck4, slvl4,
                   m1.period, m1.high, m1.valid, m1.stuck, m1.lvl);
      end
    end
  end

  int vcnt = 0, lastp = 0, lasth = 0;
  int vcnt4 = 0, lastp4 = 0, lasth4 = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt++; lastp = int'(period_cnt); lasth = int'(high_cnt);
    end
    if (valid4 === 1'b1) begin
      vcnt4++; lastp4 = int'(period4); lasth4 = int'(high4);
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic sq(input bit which, input int hi, input int lo,
                    input int n);
    for (int i = 0; i < n; i++) begin
      if (which) sig4 = 1'b1; else sig = 1'b1;
      wait_n(hi);
      if (which) sig4 = 1'b0; else sig = 1'b0;
      wait_n(lo);
    end
  endtask

  int vb, lat;

  initial begin
    rst = 1'b1;
    wait_n(1);
    chk_en = 1'b1;
    wait_n(2);
    chk("rst_period", period_cnt, 0);
    chk("rst_high", high_cnt, 0);
    chk("rst_flags", {valid, stuck, stuck_level}, 0);
    rst = 1'b0;
    wait_n(3);

    // 26/26 square wave, three periods -> two reports
    vb = vcnt;
    sq(0, 26, 26, 3);
    chk("sq26_count", vcnt - vb, 2);
    chk("sq26_period", lastp, 52);
    chk("sq26_high", lasth, 26);

    // rise-to-valid latency
    sig = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      wait_n(1);
      if (valid === 1'b1 && lat == 0) lat = i;
    end
    chk("latency", lat, 4);

    // 101/100 wave, then a duty change
    wait_n(91);
    sig = 1'b0;
    wait_n(100);
    sq(0, 101, 100, 2);
    chk("p201_period", lastp, 201);
    chk("p201_high", lasth, 101);
    sq(0, 60, 141, 2);
    chk("duty_period", lastp, 201);
    chk("duty_high", lasth, 60);

    // stuck low, then stuck high with exact timing
    vb = vcnt;
    wait_n(1100);
    chk("stuck_low", stuck, 1);
    chk("stuck_low_lvl", stuck_level, 0);
    sig = 1'b1;
    wait_n(1002);
    chk("stuck_hi_early", stuck, 0);
    wait_n(1);
    chk("stuck_hi", stuck, 1);
    chk("stuck_hi_lvl", stuck_level, 1);
    sig = 1'b0;
    wait_n(30);
    sig = 1'b1;
    wait_n(5);
    chk("stuck_clear", stuck, 0);
    chk("stuck_no_valid", vcnt - vb, 0);
    wait_n(21);
    sig = 1'b0;
    wait_n(26);
    sq(0, 26, 26, 2);

    // reset mid-period
    sig = 1'b1;
    wait_n(10);
    rst = 1'b1;
    sig = 1'b0;
    wait_n(2);
    chk("mid_rst_period", period_cnt, 0);
    chk("mid_rst_high", high_cnt, 0);
    chk("mid_rst_flags", {valid, stuck, stuck_level}, 0);
    rst = 1'b0;
    wait_n(5);
    vb = vcnt;
    sq(0, 26, 26, 2);
    chk("post_rst_count", vcnt - vb, 1);
    chk("post_rst_period", lastp, 52);

    // narrow instance: stuck high, no wrap
    sig4 = 1'b1;
    wait_n(17);
    chk("w4_stuck_early", stuck4, 0);
    wait_n(1);
    chk("w4_stuck", stuck4, 1);
    chk("w4_stuck_lvl", slvl4, 1);
    wait_n(2);
    sig4 = 1'b0;
    wait_n(10);

    // rise coincident with cnt == TIMEOUT
    vb = vcnt4;
    sq(1, 5, 10, 3);
    sig4 = 1'b1;
    wait_n(4);
    chk("w4_edge_count", vcnt4 - vb, 3);
    chk("w4_edge_period", lastp4, 15);
    chk("w4_edge_high", lasth4, 5);
    chk("w4_edge_nostuck", stuck4, 0);

    // fall at cnt == max: edge wins, then saturated timeout
    wait_n(11);
    sig4 = 1'b0;
    wait_n(3);
    chk("w4_fall_nostuck", stuck4, 0);
    wait_n(7);
    chk("w4_sat_stuck", stuck4, 1);
    chk("w4_sat_lvl", slvl4, 0);

    wait_n(5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
